uart_xmt_control: RTL and testbench

Control unit that sequences the UART transmit datapath: Datapath_Unit holds the data and shift registers plus the bit counter.
- Accepts bytes from a host through a one-deep write handshake.
- Generates the baud tick internally.
- Issues the Load_XMT_DR, Load_XMT_shftreg, start, shift and clear strobes so that each byte leaves Serial_out as one start bit, WORD_SIZE data bits (LSB first) and STOP_BITS stop bits.
- Sits between the host bus logic and Datapath_Unit, one instance per transmitter.

---
 rtl/uart_pkg.sv | 22 ++
 rtl/uart_baud_gen.sv | 38 +++
 rtl/uart_xmt_control.sv | 122 ++++++++++++
 tb/tb_uart_xmt_control.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default frame parameters and a
// counter-width helper used by the transmit controller and the baud generator.
package uart_pkg;

   localparam int WORD_SIZE_DEF    = 8;
   localparam int CLKS_PER_BIT_DEF = 16;
   localparam int STOP_BITS_DEF    = 1;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } xmt_state_e;

   // Never return a zero width, even for a divide-by-one counter.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Up-counting baud divider with synchronous zero; tick marks the last clock
// of each serial bit period. Shared by the transmitter and receiver.
module uart_baud_gen
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   localparam int CW          = cnt_width(CLKS_PER_BIT)
) (
   input  logic clk_i,
   input  logic rst_b_i,
   input  logic zero_i,
   input  logic en_i,
   output logic tick_o
);

   logic [CW-1:0] cnt_q;
   logic [CW-1:0] cnt_d;

   assign tick_o = (cnt_q == CW'(CLKS_PER_BIT - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (zero_i) begin
         cnt_d = '0;
      end else if (en_i) begin
         cnt_d = tick_o ? '0 : cnt_q + CW'(1);
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_b_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/uart_xmt_control.sv
// UART transmit sequencer: one-deep host write buffer plus the strobes that
// drive the datapath through start, data and stop bits.
//
//   state | meaning
//   IDLE  | no frame; waits for a buffered byte
//   LOAD  | copy data register into shift register, free the buffer
//   START | force start bit, clear bit count, restart baud divider
//   DATA  | shift one bit per baud tick until the datapath reports all bits out
//   STOP  | hold line high for STOP_BITS bit periods, then Done
module uart_xmt_control
   import uart_pkg::*;
#(
   parameter int WORD_SIZE    = WORD_SIZE_DEF,
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int STOP_BITS    = STOP_BITS_DEF
) (
   input  logic Clock,
   input  logic rst_b,
   input  logic Wr_req,
   output logic Wr_ack,
   input  logic BC_lt_BCmax,
   output logic Load_XMT_DR,
   output logic Load_XMT_shftreg,
   output logic start,
   output logic shift,
   output logic clear,
   output logic Buf_full,
   output logic Busy,
   output logic Done
);

   if (WORD_SIZE < 1) begin : g_bad_word
      $error("uart_xmt_control: WORD_SIZE must be at least 1");
   end
   if (CLKS_PER_BIT < 2) begin : g_bad_cpb
      $error("uart_xmt_control: CLKS_PER_BIT must be at least 2");
   end
   if ((STOP_BITS < 1) || (STOP_BITS > 2)) begin : g_bad_stop
      $error("uart_xmt_control: STOP_BITS must be 1 or 2");
   end

   xmt_state_e state_q;
   xmt_state_e state_d;
   logic       buf_full_q;
   logic       buf_full_d;
   logic       stop_cnt_q;
   logic       stop_cnt_d;
   logic       tick;
   logic       last_stop;

   uart_baud_gen #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clk_i   (Clock),
      .rst_b_i (rst_b),
      .zero_i  (state_q == START),
      .en_i    ((state_q == DATA) || (state_q == STOP)),
      .tick_o  (tick)
   );

   always_ff @(posedge Clock) begin
      if (!rst_b) begin
         state_q    <= IDLE;
         buf_full_q <= 1'b0;
         stop_cnt_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         buf_full_q <= buf_full_d;
         stop_cnt_q <= stop_cnt_d;
      end
   end

   // A byte written during LOAD or on the final stop tick keeps the buffer full.
   always_comb begin
      state_d    = state_q;
      stop_cnt_d = stop_cnt_q;
      buf_full_d = buf_full_q;
      if (state_q == LOAD) begin
         buf_full_d = 1'b0;
      end
      if (Load_XMT_DR) begin
         buf_full_d = 1'b1;
      end
      case (state_q)
         IDLE: begin
            if (buf_full_q) begin
               state_d = LOAD;
            end
         end
         LOAD:  state_d = START;
         START: state_d = DATA;
         DATA: begin
            if (!BC_lt_BCmax) begin
               state_d    = STOP;
               stop_cnt_d = 1'b0;
            end
         end
         STOP: begin
            if (last_stop) begin
               state_d = (buf_full_q || Load_XMT_DR) ? LOAD : IDLE;
            end else if (tick) begin
               stop_cnt_d = stop_cnt_q + 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      last_stop        = (state_q == STOP) && tick && (stop_cnt_q == 1'(STOP_BITS - 1));
      Load_XMT_DR      = Wr_req && (!buf_full_q || (state_q == LOAD));
      Wr_ack           = Load_XMT_DR;
      Load_XMT_shftreg = (state_q == LOAD);
      start            = (state_q == START);
      shift            = (state_q == DATA) && tick && BC_lt_BCmax;
      clear            = (state_q == START) || last_stop;
      Buf_full         = buf_full_q;
      Busy             = (state_q != IDLE);
      Done             = last_stop;
   end

endmodule

// File: tb/tb_uart_xmt_control.sv
// Bench: two transmitters (one and two stop bits) with datapath stand-ins,
// checked every cycle against a frame-timeline reference model.
module tb_uart_xmt_control;

   localparam int WS  = 8;
   localparam int CPB = 4;

   logic       clk;
   logic       rst_b;
   logic       wr_req;
   logic [7:0] data_bus;

   logic wr_ack [2];
   logic ld_dr  [2];
   logic ld_sh  [2];
   logic start_s[2];
   logic shift_s[2];
   logic clear_s[2];
   logic buf_f  [2];
   logic busy   [2];
   logic done   [2];
   logic bc_lt  [2];
   logic ser    [2];

   logic [WS-1:0] dp_dr[2];
   logic [WS:0]   dp_sh[2];
   logic [3:0]    dp_bc[2];

   bit         m_act  [2];
   int         m_pos  [2];
   bit         m_buf  [2];
   logic [7:0] m_byte [2];
   logic [7:0] m_frame[2];

   int n_checks = 0;
   int n_pass   = 0;
   int shift_cnt[2];
   int done_cnt [2];

   uart_xmt_control #(.WORD_SIZE(WS), .CLKS_PER_BIT(CPB), .STOP_BITS(1)) u_dut0 (
      .Clock(clk), .rst_b(rst_b), .Wr_req(wr_req), .Wr_ack(wr_ack[0]),
      .BC_lt_BCmax(bc_lt[0]), .Load_XMT_DR(ld_dr[0]), .Load_XMT_shftreg(ld_sh[0]),
      .start(start_s[0]), .shift(shift_s[0]), .clear(clear_s[0]),
      .Buf_full(buf_f[0]), .Busy(busy[0]), .Done(done[0]));

   uart_xmt_control #(.WORD_SIZE(WS), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) u_dut1 (
      .Clock(clk), .rst_b(rst_b), .Wr_req(wr_req), .Wr_ack(wr_ack[1]),
      .BC_lt_BCmax(bc_lt[1]), .Load_XMT_DR(ld_dr[1]), .Load_XMT_shftreg(ld_sh[1]),
      .start(start_s[1]), .shift(shift_s[1]), .clear(clear_s[1]),
      .Buf_full(buf_f[1]), .Busy(busy[1]), .Done(done[1]));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Datapath stand-in: data register, shift register, bit counter.
   always @(posedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (!rst_b) begin
            dp_sh[i] <= '1;
            dp_bc[i] <= '0;
            dp_dr[i] <= '0;
         end else begin
            if (ld_dr[i]) dp_dr[i] <= data_bus;
            if (ld_sh[i]) dp_sh[i] <= {dp_dr[i], 1'b1};
            else if (start_s[i]) dp_sh[i][0] <= 1'b0;
            else if (shift_s[i]) dp_sh[i] <= {1'b1, dp_sh[i][WS:1]};
            if (clear_s[i]) dp_bc[i] <= '0;
            else if (shift_s[i]) dp_bc[i] <= dp_bc[i] + 4'd1;
         end
      end
   end

   assign bc_lt[0] = dp_bc[0] < 4'(WS + 1);
   assign bc_lt[1] = dp_bc[1] < 4'(WS + 1);
   assign ser[0]   = dp_sh[0][0];
   assign ser[1]   = dp_sh[1][0];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp)
         $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, obs, exp);
      else
         n_pass++;
   endtask

   // Frame timeline: pos 0 = LOAD, 1 = START, then (1+WS+stops) bits of CPB cycles.
   function automatic int last_pos(input int i);
      return 2 + (1 + WS + (i + 1)) * CPB - 1;
   endfunction

   function automatic logic exp_line(input int i);
      int         k;
      logic [7:0] fb;
      if (!m_act[i] || m_pos[i] < 2) return 1'b1;
      k  = (m_pos[i] - 2) / CPB;
      fb = m_frame[i];
      if (k == 0) return 1'b0;
      if (k <= WS) return fb[k-1];
      return 1'b1;
   endfunction

   task automatic check_inst(input int i);
      bit   act;
      int   p;
      logic e_ack, e_done, e_shift;
      act     = m_act[i];
      p       = m_pos[i];
      e_ack   = wr_req && (!m_buf[i] || (act && p == 0));
      e_done  = act && (p == last_pos(i));
      e_shift = act && (p >= 2) && (p < 2 + (WS + 1) * CPB) && (((p - 2) % CPB) == CPB - 1);
      chk($sformatf("s%0d_wr_ack", i + 1),  32'(wr_ack[i]),  32'(e_ack));
      chk($sformatf("s%0d_ld_dr", i + 1),   32'(ld_dr[i]),   32'(e_ack));
      chk($sformatf("s%0d_ld_sh", i + 1),   32'(ld_sh[i]),   32'(act && p == 0));
      chk($sformatf("s%0d_start", i + 1),   32'(start_s[i]), 32'(act && p == 1));
      chk($sformatf("s%0d_shift", i + 1),   32'(shift_s[i]), 32'(e_shift));
      chk($sformatf("s%0d_clear", i + 1),   32'(clear_s[i]), 32'((act && p == 1) || e_done));
      chk($sformatf("s%0d_buf_full", i + 1), 32'(buf_f[i]),  32'(m_buf[i]));
      chk($sformatf("s%0d_busy", i + 1),    32'(busy[i]),    32'(act));
      chk($sformatf("s%0d_done", i + 1),    32'(done[i]),    32'(e_done));
      chk($sformatf("s%0d_serial", i + 1),  32'(ser[i]),     32'(exp_line(i)));
   endtask

   task automatic advance_inst(input int i);
      bit ack;
      bit mb;
      mb  = m_buf[i];
      ack = wr_req && (!mb || (m_act[i] && m_pos[i] == 0));
      if (m_act[i] && m_pos[i] == 0) begin
         m_frame[i] = m_byte[i];
         m_buf[i]   = 1'b0;
      end
      if (ack) begin
         m_byte[i] = data_bus;
         m_buf[i]  = 1'b1;
      end
      if (m_act[i]) begin
         if (m_pos[i] == last_pos(i)) begin
            m_act[i] = mb || ack;
            m_pos[i] = 0;
         end else begin
            m_pos[i] = m_pos[i] + 1;
         end
      end else if (mb) begin
         m_act[i] = 1'b1;
         m_pos[i] = 0;
      end
   endtask

   task automatic cycle(input bit wr, input logic [7:0] d);
      wr_req   = wr;
      data_bus = d;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         check_inst(i);
         shift_cnt[i] += int'(shift_s[i]);
         done_cnt[i]  += int'(done[i]);
         advance_inst(i);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic reset_cycle();
      rst_b  = 1'b0;
      wr_req = 1'b0;
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         m_act[i] = 1'b0;
         m_pos[i] = 0;
         m_buf[i] = 1'b0;
      end
      @(posedge clk);
      #1;
      rst_b = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) cycle(1'b0, 8'h00);
   endtask

   initial begin
      int lat;
      rst_b    = 1'b0;
      wr_req   = 1'b0;
      data_bus = 8'h00;
      for (int i = 0; i < 2; i++) begin
         m_byte[i] = 8'h00;
         m_frame[i] = 8'h00;
      end
      @(posedge clk);
      #1;
      reset_cycle();
      idle(4);

      // single byte: latency, shift pulses, one Done each
      shift_cnt = '{0, 0};
      done_cnt  = '{0, 0};
      cycle(1'b1, 8'hA5);
      lat = -1;
      for (int k = 1; k <= 60; k++) begin
         if (lat < 0 && ser[0] == 1'b0) lat = k;
         cycle(1'b0, 8'h00);
      end
      chk("latency_wr_to_start", 32'(lat), 32'd4);
      chk("s1_shift_pulses", 32'(shift_cnt[0]), 32'd9);
      chk("s2_shift_pulses", 32'(shift_cnt[1]), 32'd9);
      chk("s1_done_count", 32'(done_cnt[0]), 32'd1);
      chk("s2_done_count", 32'(done_cnt[1]), 32'd1);

      // two-stop-bit frame of zeros
      cycle(1'b1, 8'h00);
      idle(60);

      // back-to-back frames
      cycle(1'b1, 8'h55);
      idle(10);
      cycle(1'b1, 8'h3C);
      idle(110);

      // overflow: third write rejected while buffer full
      cycle(1'b1, 8'h11);
      idle(10);
      cycle(1'b1, 8'h22);
      cycle(1'b1, 8'h33);
      idle(110);

      // write landing in the LOAD cycle
      cycle(1'b1, 8'h81);
      idle(1);
      cycle(1'b1, 8'h7E);
      idle(110);

      // reset in the middle of the data phase
      cycle(1'b1, 8'hC3);
      idle(15);
      reset_cycle();
      done_cnt = '{0, 0};
      idle(30);
      chk("s1_no_done_after_abort", 32'(done_cnt[0]), 32'd0);
      chk("s2_no_done_after_abort", 32'(done_cnt[1]), 32'd0);

      // random traffic with rare resets
      for (int k = 0; k < 4000; k++) begin
         if ($urandom_range(0, 599) == 0) reset_cycle();
         else cycle($urandom_range(0, 5) == 0, 8'($urandom));
      end
      idle(60);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
